// File: rtl/fp_cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_cmp_pkg
//  Description : Shared definitions for the RV32F compare / min-max unit:
//                FUNCT encodings, default canonical NaN, FCLASS bit
//                positions and the per-operand classification record.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_cmp_pkg;

    // FUNCT encodings carried on the request
    localparam logic [2:0] FN_FLE    = 3'b000;
    localparam logic [2:0] FN_FLT    = 3'b001;
    localparam logic [2:0] FN_FEQ    = 3'b010;
    localparam logic [2:0] FN_FMIN   = 3'b100;
    localparam logic [2:0] FN_FMAX   = 3'b101;
    localparam logic [2:0] FN_FCLASS = 3'b111;

    // Result of FMIN/FMAX when both operands are NaN
    localparam logic [31:0] CANON_NAN_DEF = 32'h7FC0_0000;

    // One-hot bit positions of the FCLASS result
    localparam int CLS_NEG_INF  = 0;
    localparam int CLS_NEG_NORM = 1;
    localparam int CLS_NEG_SUB  = 2;
    localparam int CLS_NEG_ZERO = 3;
    localparam int CLS_POS_ZERO = 4;
    localparam int CLS_POS_SUB  = 5;
    localparam int CLS_POS_NORM = 6;
    localparam int CLS_POS_INF  = 7;
    localparam int CLS_SNAN     = 8;
    localparam int CLS_QNAN     = 9;
    localparam int CLS_W        = 10;

    // Per-operand classification, registered alongside the operand in S1
    typedef struct packed {
        logic sign;
        logic is_nan;
        logic is_snan;
        logic is_inf;
        logic is_zero;
        logic is_sub;
    } fp_class_t;

endpackage : fp_cmp_pkg
`default_nettype wire

// File: rtl/fp_compare_pipe_classify.sv
`default_nettype none
// ============================================================================
//  Module      : fp_classify
//  Description : Combinational IEEE-754 single-precision operand classifier.
//  Ports       : i_op      operand bits
//                o_sign    sign bit
//                o_is_nan  any NaN (exp all ones, mantissa non-zero)
//                o_is_snan signalling NaN (NaN with quiet bit clear)
//                o_is_inf  +/- infinity
//                o_is_zero +/- zero
//                o_is_sub  subnormal (exp zero, mantissa non-zero)
//  Revision    : 1.0  initial release
// ============================================================================
module fp_classify (
    input  logic [31:0] i_op,
    output logic        o_sign,
    output logic        o_is_nan,
    output logic        o_is_snan,
    output logic        o_is_inf,
    output logic        o_is_zero,
    output logic        o_is_sub
);

    logic [7:0]  w_exp;
    logic [22:0] w_mant;
    logic        w_exp_max;
    logic        w_exp_min;
    logic        w_mant_nz;

    assign w_exp     = i_op[30:23];
    assign w_mant    = i_op[22:0];
    assign w_exp_max = (w_exp == 8'hFF);
    assign w_exp_min = (w_exp == 8'h00);
    assign w_mant_nz = (w_mant != 23'd0);

    assign o_sign    = i_op[31];
    assign o_is_nan  = w_exp_max &  w_mant_nz;
    // Quiet bit is the mantissa MSB; a NaN with it clear is signalling
    assign o_is_snan = w_exp_max &  w_mant_nz & ~w_mant[22];
    assign o_is_inf  = w_exp_max & ~w_mant_nz;
    assign o_is_zero = w_exp_min & ~w_mant_nz;
    assign o_is_sub  = w_exp_min &  w_mant_nz;

endmodule : fp_classify
`default_nettype wire

// File: rtl/fp_compare_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_compare_pipe
//  Description : Two-stage pipelined RV32F FEQ/FLT/FLE/FMIN/FMAX unit with
//                valid/ready handshake and NV flag output.
//                Optional FCLASS.S (FUNCT=111) when FP_CMP_FCLASS_EN is
//                defined; otherwise 111 yields R=0, NV=0.
//  Ports       : CLK/RST            clock, async active-high reset
//                IN_VALID/IN_READY  request handshake
//                OP_A/OP_B          operands (IEEE single bits)
//                FUNCT              operation select
//                IN_TAG             destination tag
//                OUT_VALID/OUT_READY result handshake
//                R, OUT_TAG, NV     result, its tag, invalid flag
//  Revision    : 1.0  initial release
// ============================================================================
module fp_compare_pipe
    import fp_cmp_pkg::*;
#(
    parameter int          TAG_W     = 5,
    parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      OP_A,
    input  logic [31:0]      OP_B,
    input  logic [2:0]       FUNCT,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      R,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             NV
);

    // ------------------------------------------------------------------
    // Operand classification (before S1 so the class is registered)
    // ------------------------------------------------------------------
    fp_class_t w_cls_a;
    fp_class_t w_cls_b;

    fp_classify u_cls_a (
        .i_op      (OP_A),
        .o_sign    (w_cls_a.sign),
        .o_is_nan  (w_cls_a.is_nan),
        .o_is_snan (w_cls_a.is_snan),
        .o_is_inf  (w_cls_a.is_inf),
        .o_is_zero (w_cls_a.is_zero),
        .o_is_sub  (w_cls_a.is_sub)
    );

    fp_classify u_cls_b (
        .i_op      (OP_B),
        .o_sign    (w_cls_b.sign),
        .o_is_nan  (w_cls_b.is_nan),
        .o_is_snan (w_cls_b.is_snan),
        .o_is_inf  (w_cls_b.is_inf),
        .o_is_zero (w_cls_b.is_zero),
        .o_is_sub  (w_cls_b.is_sub)
    );

    // ------------------------------------------------------------------
    // Handshake chain
    // ------------------------------------------------------------------
    logic             r_s1_valid;
    logic [31:0]      r_s1_a;
    logic [31:0]      r_s1_b;
    logic [2:0]       r_s1_funct;
    logic [TAG_W-1:0] r_s1_tag;
    fp_class_t        r_s1_cls_a;
    fp_class_t        r_s1_cls_b;

    logic             r_s2_valid;
    logic [31:0]      r_s2_r;
    logic             r_s2_nv;
    logic [TAG_W-1:0] r_s2_tag;

    logic             w_s2_ready;

    assign w_s2_ready = ~r_s2_valid | OUT_READY;
    assign IN_READY   = ~r_s1_valid | w_s2_ready;

    // ------------------------------------------------------------------
    // Stage 1: capture request and operand classes
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_funct <= '0;
            r_s1_tag   <= '0;
            r_s1_cls_a <= '0;
            r_s1_cls_b <= '0;
        end else if (IN_READY) begin
            r_s1_valid <= IN_VALID;
            if (IN_VALID) begin
                r_s1_a     <= OP_A;
                r_s1_b     <= OP_B;
                r_s1_funct <= FUNCT;
                r_s1_tag   <= IN_TAG;
                r_s1_cls_a <= w_cls_a;
                r_s1_cls_b <= w_cls_b;
            end
        end
    end

    // ------------------------------------------------------------------
    // Ordering between two non-NaN operands
    // ------------------------------------------------------------------
    logic w_any_nan;
    logic w_any_snan;
    logic w_both_zero;
    logic w_eq;
    logic w_lt;
    logic w_mag_lt;
    logic w_mag_gt;

    assign w_any_nan   = r_s1_cls_a.is_nan  | r_s1_cls_b.is_nan;
    assign w_any_snan  = r_s1_cls_a.is_snan | r_s1_cls_b.is_snan;
    assign w_both_zero = r_s1_cls_a.is_zero & r_s1_cls_b.is_zero;
    assign w_eq        = w_both_zero | (r_s1_a == r_s1_b);
    assign w_mag_lt    = (r_s1_a[30:0] < r_s1_b[30:0]);
    assign w_mag_gt    = (r_s1_a[30:0] > r_s1_b[30:0]);

    always_comb begin
        w_lt = 1'b0;
        if (w_both_zero) begin
            w_lt = 1'b0;
        end else if (r_s1_cls_a.sign != r_s1_cls_b.sign) begin
            // Differing signs: the negative operand is smaller
            w_lt = r_s1_cls_a.sign;
        end else if (r_s1_cls_a.sign) begin
            // Both negative: larger magnitude is the smaller value
            w_lt = w_mag_gt;
        end else begin
            w_lt = w_mag_lt;
        end
    end

    // A selected over B for FMIN; the (w_eq & sign_a) term makes
    // FMIN(-0,+0) = -0 and, inverted for FMAX, FMAX(-0,+0) = +0.
    logic w_a_is_min;
    assign w_a_is_min = w_lt | (w_eq & r_s1_cls_a.sign);

`ifdef FP_CMP_FCLASS_EN
    logic [CLS_W-1:0] w_class;

    always_comb begin
        w_class = '0;
        if (r_s1_cls_a.is_nan) begin
            if (r_s1_cls_a.is_snan) w_class[CLS_SNAN] = 1'b1;
            else                    w_class[CLS_QNAN] = 1'b1;
        end else if (r_s1_cls_a.is_inf) begin
            if (r_s1_cls_a.sign) w_class[CLS_NEG_INF] = 1'b1;
            else                 w_class[CLS_POS_INF] = 1'b1;
        end else if (r_s1_cls_a.is_zero) begin
            if (r_s1_cls_a.sign) w_class[CLS_NEG_ZERO] = 1'b1;
            else                 w_class[CLS_POS_ZERO] = 1'b1;
        end else if (r_s1_cls_a.is_sub) begin
            if (r_s1_cls_a.sign) w_class[CLS_NEG_SUB] = 1'b1;
            else                 w_class[CLS_POS_SUB] = 1'b1;
        end else begin
            if (r_s1_cls_a.sign) w_class[CLS_NEG_NORM] = 1'b1;
            else                 w_class[CLS_POS_NORM] = 1'b1;
        end
    end
`endif

    // Class bits only FCLASS looks at; collapsed here so both builds
    // consume every registered field.
    logic w_unused_cls;
    assign w_unused_cls = ^{r_s1_cls_a.is_inf, r_s1_cls_a.is_sub,
                            r_s1_cls_b.is_inf, r_s1_cls_b.is_sub};

    // ------------------------------------------------------------------
    // Result selection
    // ------------------------------------------------------------------
    logic [31:0] w_r;
    logic        w_nv;

    always_comb begin
        w_r  = '0;
        w_nv = 1'b0;
        case (r_s1_funct)
            FN_FLT: begin
                w_r[0] = ~w_any_nan & w_lt;
                w_nv   = w_any_nan;
            end
            FN_FLE: begin
                w_r[0] = ~w_any_nan & (w_lt | w_eq);
                w_nv   = w_any_nan;
            end
            FN_FEQ: begin
                // Quiet comparison: only signalling NaNs raise NV
                w_r[0] = ~w_any_nan & w_eq;
                w_nv   = w_any_snan;
            end
            FN_FMIN, FN_FMAX: begin
                if (r_s1_cls_a.is_nan && r_s1_cls_b.is_nan) begin
                    w_r = CANON_NAN;
                end else if (r_s1_cls_a.is_nan) begin
                    w_r = r_s1_b;
                end else if (r_s1_cls_b.is_nan) begin
                    w_r = r_s1_a;
                end else if (r_s1_funct == FN_FMIN) begin
                    w_r = w_a_is_min ? r_s1_a : r_s1_b;
                end else begin
                    w_r = w_a_is_min ? r_s1_b : r_s1_a;
                end
                w_nv = w_any_snan;
            end
`ifdef FP_CMP_FCLASS_EN
            FN_FCLASS: begin
                w_r[CLS_W-1:0] = w_class;
                w_nv           = 1'b0;
            end
`endif
            default: begin
                w_r  = '0;
                w_nv = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 2: output register, held while the consumer stalls
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s2_valid <= 1'b0;
            r_s2_r     <= '0;
            r_s2_nv    <= 1'b0;
            r_s2_tag   <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_r   <= w_r;
                r_s2_nv  <= w_nv;
                r_s2_tag <= r_s1_tag;
            end
        end
    end

    assign OUT_VALID = r_s2_valid;
    assign R         = r_s2_r;
    assign NV        = r_s2_nv;
    assign OUT_TAG   = r_s2_tag;

endmodule : fp_compare_pipe
`default_nettype wire

// File: tb/tb_fp_compare_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_compare_pipe
//  Description : Self-checking bench for fp_compare_pipe: vector table run
//                through a scoreboard queue, plus latency, back-pressure
//                and mid-flight reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp_compare_pipe;
    import fp_cmp_pkg::*;

    localparam int TAG_W = 5;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             IN_VALID = 1'b0;
    logic             IN_READY;
    logic [31:0]      OP_A = '0;
    logic [31:0]      OP_B = '0;
    logic [2:0]       FUNCT = '0;
    logic [TAG_W-1:0] IN_TAG = '0;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b1;
    logic [31:0]      R;
    logic [TAG_W-1:0] OUT_TAG;
    logic             NV;

    fp_compare_pipe #(.TAG_W(TAG_W), .CANON_NAN(32'h7FC0_0000)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OP_A      (OP_A),
        .OP_B      (OP_B),
        .FUNCT     (FUNCT),
        .IN_TAG    (IN_TAG),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .R         (R),
        .OUT_TAG   (OUT_TAG),
        .NV        (NV)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]       f;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      r;
        logic             nv;
    } vec_t;

    typedef struct packed {
        logic [31:0]      r;
        logic             nv;
        logic [TAG_W-1:0] tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t cur_exp;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic add_vec(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic nv);
        vec_t v;
        v.f   = f;
        v.a   = a;
        v.b   = b;
        v.tag = TAG_W'((vecs.size() * 3 + 1) % 32);
        v.r   = r;
        v.nv  = nv;
        vecs.push_back(v);
    endtask

    // Called just after a negedge: monitor output, record acceptance,
    // then advance to the next negedge.
    task automatic tick(output bit acc);
        exp_t e;
        acc = 1'b0;
        #1;
        if (OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", {26'd0, R, NV, OUT_TAG}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("result{R,NV,TAG}", {26'd0, R, NV, OUT_TAG}, {26'd0, e});
            end
        end
        if (IN_VALID && IN_READY) begin
            sb.push_back(cur_exp);
            acc = 1'b1;
        end
        @(negedge CLK);
    endtask

    task automatic drive_vec(input vec_t v);
        IN_VALID = 1'b1;
        OP_A     = v.a;
        OP_B     = v.b;
        FUNCT    = v.f;
        IN_TAG   = v.tag;
        cur_exp  = '{r: v.r, nv: v.nv, tag: v.tag};
    endtask

    task automatic send(input vec_t v, input bit rnd);
        bit acc;
        int guard;
        drive_vec(v);
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 50) begin
            if (rnd) OUT_READY = 1'($urandom_range(0, 1));
            tick(acc);
            guard++;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        bit acc;
        int guard;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            tick(acc);
            guard++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   acc;
        int   idx;
        vec_t v;
        logic [31:0] fclass_exp;

`ifdef FP_CMP_FCLASS_EN
        fclass_exp = 32'h0000_0002;   // -1.0 is a negative normal
`else
        fclass_exp = 32'h0000_0000;
`endif

        add_vec(FN_FLT,  32'hBF800000, 32'h3F800000, 32'h1,        1'b0);
        add_vec(FN_FEQ,  32'h80000000, 32'h00000000, 32'h1,        1'b0);
        add_vec(FN_FLE,  32'h7FC00000, 32'h3F800000, 32'h0,        1'b1);
        add_vec(FN_FEQ,  32'h7F800001, 32'h3F800000, 32'h0,        1'b1);
        add_vec(FN_FEQ,  32'h7FC00000, 32'h3F800000, 32'h0,        1'b0);
        add_vec(FN_FMIN, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0);
        add_vec(FN_FMAX, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 1'b0);
        add_vec(FN_FMIN, 32'h7FC00000, 32'h40000000, 32'h40000000, 1'b0);
        add_vec(FN_FMAX, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0);
        add_vec(FN_FMIN, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0);
        add_vec(FN_FLT,  32'hC0000000, 32'hBF800000, 32'h1,        1'b0);
        add_vec(FN_FLT,  32'hBF800000, 32'hC0000000, 32'h0,        1'b0);
        add_vec(FN_FLE,  32'h3F800000, 32'h3F800000, 32'h1,        1'b0);
        add_vec(FN_FLT,  32'h3F800000, 32'h3F800000, 32'h0,        1'b0);
        add_vec(FN_FLE,  32'h80000000, 32'h00000000, 32'h1,        1'b0);
        add_vec(FN_FMAX, 32'h7F800001, 32'h3F800000, 32'h3F800000, 1'b1);
        add_vec(FN_FMIN, 32'hFF800000, 32'h7F800000, 32'hFF800000, 1'b0);
        add_vec(FN_FLT,  32'h00000001, 32'h00000000, 32'h0,        1'b0);
        add_vec(FN_FLT,  32'h80000001, 32'h00000000, 32'h1,        1'b0);
        add_vec(3'b011,  32'h3F800000, 32'h40000000, 32'h0,        1'b0);
        add_vec(FN_FMIN, 32'hC0400000, 32'h40400000, 32'hC0400000, 1'b0);
        add_vec(FN_FMAX, 32'hC0400000, 32'h40400000, 32'h40400000, 1'b0);
        add_vec(FN_FEQ,  32'h3F800000, 32'h3F800000, 32'h1,        1'b0);
        add_vec(FN_FMAX, 32'h7F800001, 32'h7F800001, 32'h7FC00000, 1'b1);
        add_vec(FN_FLT,  32'h7F800000, 32'h7F800001, 32'h0,        1'b1);
        add_vec(FN_FCLASS, 32'hBF800000, 32'h0,      fclass_exp,   1'b0);

        // ---------------- reset state ----------------
        repeat (2) @(negedge CLK);
        chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_r",         64'(R),         64'd0);
        chk("rst_tag",       64'(OUT_TAG),   64'd0);
        chk("rst_nv",        64'(NV),        64'd0);
        RST = 1'b0;
        #1;
        chk("rst_in_ready",  64'(IN_READY),  64'd1);
        @(negedge CLK);

        // ---------------- two-cycle latency ----------------
        IN_VALID = 1'b1; OP_A = 32'hBF800000; OP_B = 32'h3F800000;
        FUNCT = FN_FLT; IN_TAG = 5'd7; OUT_READY = 1'b1;
        #1;
        chk("lat_in_ready", 64'(IN_READY), 64'd1);
        @(negedge CLK);
        IN_VALID = 1'b0;
        #1;
        chk("lat_cycle1_valid", 64'(OUT_VALID), 64'd0);
        @(negedge CLK);
        #1;
        chk("lat_cycle2_result", {26'd0, OUT_VALID, R, NV, OUT_TAG},
            {26'd0, 1'b1, 32'h1, 1'b0, 5'd7});
        @(negedge CLK);

        // ---------------- table, free-flowing then random stalls -------
        OUT_READY = 1'b1;
        for (int i = 0; i < vecs.size(); i++) send(vecs[i], 1'b0);
        drain();
        for (int i = 0; i < vecs.size(); i++) send(vecs[i], 1'b1);
        drain();

        // ---------------- back-pressure ----------------
        OUT_READY = 1'b0;
        idx = 0;
        for (int s = 0; s < 5; s++) begin
            v = vecs[idx];
            v.tag = TAG_W'(11 + idx);
            drive_vec(v);
            tick(acc);
            if (acc) idx++;
            if (s >= 2) begin
                #1;
                chk("bp_in_ready_low", 64'(IN_READY), 64'd0);
                chk("bp_r_held", {31'd0, OUT_VALID, R, OUT_TAG[4:0], NV},
                    {31'd0, 1'b1, vecs[0].r, 5'd11, vecs[0].nv});
            end
        end
        chk("bp_accepts", 64'(idx), 64'd2);
        OUT_READY = 1'b1;
        while (idx < 4) begin
            v = vecs[idx];
            v.tag = TAG_W'(11 + idx);
            send(v, 1'b0);
            idx++;
        end
        drain();

        // ---------------- reset with ops in flight ----------------
        OUT_READY = 1'b0;
        send(vecs[5], 1'b0);
        send(vecs[6], 1'b0);
        IN_VALID = 1'b0;
        #1;
        chk("pre_rst_valid", 64'(OUT_VALID), 64'd1);
        #1;
        RST = 1'b1;
        #1;
        chk("midrst_out", {26'd0, OUT_VALID, R, NV, OUT_TAG}, 64'd0);
        sb.delete();
        @(negedge CLK);
        RST = 1'b0;
        OUT_READY = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick(acc);
            chk("post_rst_no_stale", 64'(OUT_VALID), 64'd0);
        end

        // pipeline still works after reset
        send(vecs[0], 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fp_compare_pipe
`default_nettype wire
